// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath definitions: marker byte values and the ECS
// reader state encoding.
package jpeg_pkg;

    localparam logic [7:0] MRK_FF = 8'hFF;
    localparam logic [7:0] STUFF  = 8'h00;
    localparam logic [7:0] RST0   = 8'hD0;
    localparam logic [7:0] RST7   = 8'hD7;
    localparam logic [7:0] EOI    = 8'hD9;

    typedef enum logic [1:0] {
        S_DATA   = 2'd0,
        S_FF     = 2'd1,
        S_MARKER = 2'd2
    } ecs_state_t;

    // True for the restart markers RST0..RST7.
    function automatic logic is_rst_marker(input logic [7:0] code);
        return (code >= RST0) && (code <= RST7);
    endfunction

endpackage

// File: rtl/jpeg_bitbuf_shift.sv
// Combinational funnel shifter for a left-aligned bit buffer.
// Removes consume_len bits from the MSB end, then optionally appends one
// byte directly after the remaining bits. Bits beyond the count are kept
// at zero, so the buffer is always zero-filled past the valid region.
// The caller guarantees consume_len <= count and that the result fits.
module jpeg_bitbuf_shift #(
    parameter int BUF_W = 32,
    parameter int CNT_W = $clog2(BUF_W + 1),
    parameter int LEN_W = 5
) (
    input  logic [BUF_W-1:0] bit_buf,
    input  logic [CNT_W-1:0] count,
    input  logic [LEN_W-1:0] consume_len,
    input  logic             append_en,
    input  logic [7:0]       append_byte,
    output logic [BUF_W-1:0] buf_next,
    output logic [CNT_W-1:0] count_next
);

    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] ins;
    logic [CNT_W-1:0] remaining;

    // Drop consumed bits, then place the new byte right behind what is left.
    always_comb begin
        shifted    = bit_buf << consume_len;
        remaining  = count - CNT_W'(consume_len);
        ins        = {append_byte, {(BUF_W-8){1'b0}}} >> remaining;
        buf_next   = shifted | (append_en ? ins : '0);
        count_next = remaining + (append_en ? CNT_W'(8) : '0);
    end

endmodule

// File: rtl/jpeg_ecs_bit_reader.sv
// Decoder-side entropy-coded-segment front end. Removes 0x00 stuff bytes
// after 0xFF, discards 0xFF fill bytes, detects markers, and presents a
// left-aligned peek window to the Huffman decoder.
//
// Handshake: a byte transfers on any rising edge where s_valid && s_ready.
// s_valid may be held while s_ready is low; s_data must stay stable while
// s_valid is high and the byte has not transferred. s_ready depends only
// on registered state (never on consume in the same cycle).
module jpeg_ecs_bit_reader
    import jpeg_pkg::*;
#(
    parameter int BUF_W  = 32,
    parameter int PEEK_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [7:0]                  s_data,
    output logic [PEEK_W-1:0]           peek_bits,
    output logic [$clog2(BUF_W+1)-1:0]  bits_avail,
    input  logic                        consume_valid,
    input  logic [$clog2(PEEK_W+1)-1:0] consume_len,
    output logic                        marker_valid,
    output logic [7:0]                  marker_code,
    input  logic                        marker_ack,
    output logic                        err_underflow
);

    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int LEN_W = $clog2(PEEK_W + 1);

    // Current parser state; named for checker binding.
    ecs_state_t       state;
    logic [BUF_W-1:0] bit_buf;

    logic             accept;
    logic             ack_now;
    logic             len_bad;
    logic             cons_ok;
    logic [LEN_W-1:0] eff_len;
    logic             append_en;
    logic [7:0]       append_byte;
    logic [BUF_W-1:0] buf_next;
    logic [CNT_W-1:0] count_next;

    // Ready whenever a full byte fits and no marker is waiting; low in reset.
    assign s_ready = !rst && (state != S_MARKER)
                     && (bits_avail <= CNT_W'(BUF_W - 8));

    assign accept    = s_valid && s_ready;
    assign peek_bits = bit_buf[BUF_W-1 -: PEEK_W];

    // Decode this cycle's consume request and byte into shifter controls.
    always_comb begin
        ack_now     = marker_ack && (state == S_MARKER);
        len_bad     = (CNT_W'(consume_len) > bits_avail)
                      || (consume_len > LEN_W'(PEEK_W));
        cons_ok     = consume_valid && !ack_now && !len_bad;
        eff_len     = cons_ok ? consume_len : '0;
        append_en   = 1'b0;
        append_byte = s_data;
        if (accept) begin
            case (state)
                S_DATA: append_en = (s_data != MRK_FF);
                S_FF: begin
                    append_en   = (s_data == STUFF);
                    append_byte = MRK_FF;
                end
                default: append_en = 1'b0;
            endcase
        end
    end

    jpeg_bitbuf_shift #(
        .BUF_W (BUF_W),
        .CNT_W (CNT_W),
        .LEN_W (LEN_W)
    ) u_shift (
        .bit_buf     (bit_buf),
        .count       (bits_avail),
        .consume_len (eff_len),
        .append_en   (append_en),
        .append_byte (append_byte),
        .buf_next    (buf_next),
        .count_next  (count_next)
    );

    // Parser FSM, bit buffer, marker capture and sticky underflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_DATA;
            bit_buf       <= '0;
            bits_avail    <= '0;
            marker_valid  <= 1'b0;
            marker_code   <= 8'h00;
            err_underflow <= 1'b0;
        end else begin
            if (consume_valid && !ack_now && len_bad) begin
                err_underflow <= 1'b1;
            end
            if (ack_now) begin
                // Whatever is left before a marker is padding.
                bit_buf      <= '0;
                bits_avail   <= '0;
                marker_valid <= 1'b0;
                state        <= S_DATA;
            end else begin
                bit_buf    <= buf_next;
                bits_avail <= count_next;
                if (accept) begin
                    case (state)
                        S_DATA: begin
                            if (s_data == MRK_FF) state <= S_FF;
                        end
                        S_FF: begin
                            if (s_data == STUFF) begin
                                state <= S_DATA;
                            end else if (s_data != MRK_FF) begin
                                marker_code  <= s_data;
                                marker_valid <= 1'b1;
                                state        <= S_MARKER;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_jpeg_ecs_bit_reader.sv
// Directed bench for jpeg_ecs_bit_reader: drivers push expected
// observations into queues, monitors pop and compare.
module tb_jpeg_ecs_bit_reader;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [15:0] peek_bits;
    logic [5:0]  bits_avail;
    logic        consume_valid;
    logic [4:0]  consume_len;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        marker_ack;
    logic        err_underflow;

    typedef struct {
        string       name;
        logic [15:0] peek;
        logic [5:0]  avail;
        logic        mv;
        logic [7:0]  mc;
        logic        rdy;
        logic        err;
    } obs_t;

    obs_t       exp_q[$];
    logic [7:0] mrk_exp_q[$];
    event       sample_ev;
    int         n_asserts;
    int         n_fail;
    logic       mv_q;

    jpeg_ecs_bit_reader #(.BUF_W(32), .PEEK_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .peek_bits     (peek_bits),
        .bits_avail    (bits_avail),
        .consume_valid (consume_valid),
        .consume_len   (consume_len),
        .marker_valid  (marker_valid),
        .marker_code   (marker_code),
        .marker_ack    (marker_ack),
        .err_underflow (err_underflow)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Snapshot monitor: compares DUT outputs against the next expected entry.
    always @(sample_ev) begin
        obs_t o;
        if (exp_q.size() == 0) begin
            cmp("exp_q_underrun", 32'd1, 32'd0);
        end else begin
            o = exp_q.pop_front();
            cmp({o.name, " peek_bits"},     32'(peek_bits),     32'(o.peek));
            cmp({o.name, " bits_avail"},    32'(bits_avail),    32'(o.avail));
            cmp({o.name, " marker_valid"},  32'(marker_valid),  32'(o.mv));
            cmp({o.name, " marker_code"},   32'(marker_code),   32'(o.mc));
            cmp({o.name, " s_ready"},       32'(s_ready),       32'(o.rdy));
            cmp({o.name, " err_underflow"}, 32'(err_underflow), 32'(o.err));
        end
    end

    // Marker monitor: each new marker_valid assertion must match the queue.
    always @(negedge clk) begin
        if (!rst && marker_valid && !mv_q) begin
            if (mrk_exp_q.size() == 0) begin
                cmp("unexpected_marker", 32'(marker_code), 32'hFFFF_FFFF);
            end else begin
                cmp("marker_event_code", 32'(marker_code), 32'(mrk_exp_q.pop_front()));
            end
        end
        mv_q <= marker_valid;
    end

    // Queue an expectation, sample at the next falling edge, return at posedge+1.
    task automatic expect_obs(input string nm, input logic [15:0] pk, input logic [5:0] av,
                              input logic mv, input logic [7:0] mc, input logic rd,
                              input logic er);
        obs_t o;
        o.name = nm; o.peek = pk; o.avail = av; o.mv = mv; o.mc = mc; o.rdy = rd; o.err = er;
        exp_q.push_back(o);
        @(negedge clk);
        -> sample_ev;
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation and sample immediately, without any clock edge.
    task automatic expect_now(input string nm, input logic [15:0] pk, input logic [5:0] av,
                              input logic mv, input logic [7:0] mc, input logic rd,
                              input logic er);
        obs_t o;
        o.name = nm; o.peek = pk; o.avail = av; o.mv = mv; o.mc = mc; o.rdy = rd; o.err = er;
        exp_q.push_back(o);
        -> sample_ev;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 50) begin
                cmp("send_byte_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic consume(input logic [4:0] len);
        consume_valid = 1'b1;
        consume_len   = len;
        @(posedge clk);
        #1;
        consume_valid = 1'b0;
        consume_len   = '0;
    endtask

    task automatic ack_pulse(input logic with_consume, input logic [4:0] len);
        marker_ack    = 1'b1;
        consume_valid = with_consume;
        consume_len   = len;
        @(posedge clk);
        #1;
        marker_ack    = 1'b0;
        consume_valid = 1'b0;
        consume_len   = '0;
    endtask

    initial begin
        n_asserts     = 0;
        n_fail        = 0;
        mv_q          = 1'b0;
        rst           = 1'b1;
        s_valid       = 1'b0;
        s_data        = 8'h00;
        consume_valid = 1'b0;
        consume_len   = '0;
        marker_ack    = 1'b0;

        #2;
        expect_now("reset", 16'h0000, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain data, then a 4-bit consume.
        send_byte(8'hA5);
        send_byte(8'h3C);
        expect_obs("t1_two_bytes", 16'hA53C, 6'd16, 1'b0, 8'h00, 1'b1, 1'b0);
        consume(5'd4);
        expect_obs("t1_consume4", 16'h53C0, 6'd12, 1'b0, 8'h00, 1'b1, 1'b0);
        consume(5'd12);
        expect_obs("t1_drained", 16'h0000, 6'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Stuffed 0xFF 0x00 becomes a single data byte 0xFF.
        send_byte(8'h12);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h34);
        expect_obs("t2_stuffed", 16'h12FF, 6'd24, 1'b0, 8'h00, 1'b1, 1'b0);
        consume(5'd8);
        expect_obs("t2_consume8", 16'hFF34, 6'd16, 1'b0, 8'h00, 1'b1, 1'b0);
        consume(5'd16);

        // Fill byte then marker 0xD3; consume while pending, then ack.
        mrk_exp_q.push_back(8'hD3);
        send_byte(8'h80);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hD3);
        expect_obs("t3_marker", 16'h8000, 6'd8, 1'b1, 8'hD3, 1'b0, 1'b0);
        consume(5'd1);
        expect_obs("t3_consume_in_marker", 16'h0000, 6'd7, 1'b1, 8'hD3, 1'b0, 1'b0);
        ack_pulse(1'b0, 5'd0);
        expect_obs("t3_acked", 16'h0000, 6'd0, 1'b0, 8'hD3, 1'b1, 1'b0);

        // Full buffer backpressure, consume frees room, held byte lands.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        expect_obs("t4_full", 16'h0102, 6'd32, 1'b0, 8'hD3, 1'b0, 1'b0);
        s_valid       = 1'b1;
        s_data        = 8'h05;
        consume_valid = 1'b1;
        consume_len   = 5'd8;
        @(posedge clk);
        #1;
        consume_valid = 1'b0;
        consume_len   = '0;
        expect_obs("t4_ready_again", 16'h0203, 6'd24, 1'b0, 8'hD3, 1'b1, 1'b0);
        s_valid = 1'b0;
        expect_obs("t4_refilled", 16'h0203, 6'd32, 1'b0, 8'hD3, 1'b0, 1'b0);
        consume(5'd16);
        expect_obs("t4_consume16", 16'h0405, 6'd16, 1'b0, 8'hD3, 1'b1, 1'b0);
        consume(5'd16);

        // Underflow: consume 6 with 5 available.
        send_byte(8'hF8);
        consume(5'd3);
        expect_obs("t5_five_bits", 16'hC000, 6'd5, 1'b0, 8'hD3, 1'b1, 1'b0);
        consume(5'd6);
        expect_obs("t5_underflow", 16'hC000, 6'd5, 1'b0, 8'hD3, 1'b1, 1'b1);
        consume(5'd5);
        expect_obs("t5_sticky", 16'h0000, 6'd0, 1'b0, 8'hD3, 1'b1, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        consume(5'd17);
        ack_pulse(1'b0, 5'd0);
        consume(5'd0);
        expect_obs("t5_ignored_ops", 16'h1122, 6'd24, 1'b0, 8'hD3, 1'b1, 1'b1);
        consume(5'd16);
        expect_obs("t5_consume16", 16'h3300, 6'd8, 1'b0, 8'hD3, 1'b1, 1'b1);
        consume(5'd8);

        // Mid-cycle reset with 20 bits buffered and an 0xFF pending.
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        consume(5'd4);
        send_byte(8'hFF);
        expect_obs("t6_before_reset", 16'hBCDE, 6'd20, 1'b0, 8'hD3, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        expect_now("t6_async_reset", 16'h0000, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_byte(8'h00);
        expect_obs("t6_zero_is_data", 16'h0000, 6'd8, 1'b0, 8'h00, 1'b1, 1'b0);

        // EOI marker; ack together with an oversize consume: ack wins, no error.
        mrk_exp_q.push_back(8'hD9);
        send_byte(8'hFF);
        send_byte(8'hD9);
        expect_obs("t7_eoi", 16'h0000, 6'd8, 1'b1, 8'hD9, 1'b0, 1'b0);
        ack_pulse(1'b1, 5'd12);
        expect_obs("t7_ack_wins", 16'h0000, 6'd0, 1'b0, 8'hD9, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        cmp("pending_markers", 32'(mrk_exp_q.size()), 32'd0);
        cmp("pending_snapshots", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
